// File: rtl/mine_placer_if.sv
// Handshake, request and board-access bundle between a mine_placer and its host/board logic.
// The placer uses the slave modport; the host side (board RAMs, sequencer) uses master.
interface mine_placer_if #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int NW = $clog2(WIDTH * HEIGHT + 1);

  logic          start;
  logic          ack;
  logic [NW-1:0] total_mines;
  logic          safe_en;
  logic [XW-1:0] safe_x;
  logic [YW-1:0] safe_y;
  logic          mine_read_value;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          place_en;
  logic [NW-1:0] placed_count;
  logic          error;
  logic          q_init;
  logic          q_change_xy;
  logic          q_place;
  logic          q_done;

  modport master (
    output start, ack, total_mines, safe_en, safe_x, safe_y, mine_read_value,
    input  x, y, place_en, placed_count, error,
    input  q_init, q_change_xy, q_place, q_done
  );

  modport slave (
    input  start, ack, total_mines, safe_en, safe_x, safe_y, mine_read_value,
    output x, y, place_en, placed_count, error,
    output q_init, q_change_xy, q_place, q_done
  );
endinterface

// File: rtl/mine_placer.sv
// Places a requested number of mines at distinct pseudo-random cells of a WIDTH x HEIGHT board,
// optionally keeping the 3x3 zone around the first click clear.
module mine_placer #(
  parameter int          WIDTH  = 8,
  parameter int          HEIGHT = 8,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input logic         clk_tb,
  input logic         reset_tb,
  mine_placer_if.slave bus
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int NW = $clog2(WIDTH * HEIGHT + 1);
  localparam int CW = NW + 1;

  localparam logic [XW:0]   W_LIM  = (XW + 1)'(WIDTH);
  localparam logic [YW:0]   H_LIM  = (YW + 1)'(HEIGHT);
  localparam logic [XW:0]   X_LAST = (XW + 1)'(WIDTH - 1);
  localparam logic [YW:0]   Y_LAST = (YW + 1)'(HEIGHT - 1);
  localparam logic [CW-1:0] CELLS  = CW'(WIDTH * HEIGHT);
  localparam logic [CW-1:0] THREE  = CW'(3);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [NW-1:0] ONE_N  = NW'(1);

  localparam logic signed [XW+1:0] DX_NEG1 = '1;
  localparam logic signed [XW+1:0] DX_POS1 = {{(XW + 1){1'b0}}, 1'b1};
  localparam logic signed [YW+1:0] DY_NEG1 = '1;
  localparam logic signed [YW+1:0] DY_POS1 = {{(YW + 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_INIT,
    S_CHANGE_XY,
    S_PLACE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [15:0]   lfsr_q, lfsr_d;
  logic          lfsr_fb;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [NW-1:0] count_q, count_d;
  logic          error_q, error_d;
  logic [NW-1:0] total_q, total_d;
  logic          safe_en_q, safe_en_d;
  logic [XW-1:0] sx_q, sx_d;
  logic [YW-1:0] sy_q, sy_d;

  logic [XW-1:0] cand_x;
  logic [YW-1:0] cand_y;
  logic [NW-1:0] count_inc;
  logic          cell_valid;
  logic          in_range;
  logic          in_safe;
  logic signed [XW+1:0] dx;
  logic signed [YW+1:0] dy;
  logic [CW-1:0] cols, rows, s_cells, capacity;
  logic          too_many;
  logic          zero_req;
  logic          last_mine;

  // Fibonacci LFSR, taps 16,14,13,11: shift up, feedback into bit 0.
  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign lfsr_d[0] = lfsr_fb;

  generate
    for (genvar gi = 0; gi < 15; gi++) begin : g_lfsr_shift
      assign lfsr_d[gi+1] = lfsr_q[gi];
    end
  endgenerate

  always_ff @(posedge clk_tb or negedge reset_tb) begin
    if (!reset_tb) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign cand_x = lfsr_q[XW-1:0];
  assign cand_y = lfsr_q[XW+YW-1:XW];

  // Candidate validity, evaluated on the registered address so the board read is stable.
  assign in_range = ({1'b0, x_q} < W_LIM) && ({1'b0, y_q} < H_LIM);
  assign dx       = $signed({2'b00, x_q}) - $signed({2'b00, sx_q});
  assign dy       = $signed({2'b00, y_q}) - $signed({2'b00, sy_q});
  assign in_safe  = safe_en_q && (dx >= DX_NEG1) && (dx <= DX_POS1)
                              && (dy >= DY_NEG1) && (dy <= DY_POS1);
  assign cell_valid = in_range && !in_safe && !bus.mine_read_value;

  // Capacity uses the live request so the error decision lands on the start edge.
  always_comb begin
    cols = THREE;
    rows = THREE;
    if (bus.safe_x == '0) cols = cols - ONE_C;
    if ({1'b0, bus.safe_x} == X_LAST) cols = cols - ONE_C;
    if (bus.safe_y == '0) rows = rows - ONE_C;
    if ({1'b0, bus.safe_y} == Y_LAST) rows = rows - ONE_C;
    s_cells  = bus.safe_en ? CW'(cols * rows) : '0;
    capacity = CELLS - s_cells;
  end

  assign too_many  = {1'b0, bus.total_mines} > capacity;
  assign zero_req  = (bus.total_mines == '0);
  assign count_inc = count_q + ONE_N;
  assign last_mine = (count_inc == total_q);

  always_ff @(posedge clk_tb or negedge reset_tb) begin
    if (!reset_tb) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT: begin
        if (bus.start) begin
          if (zero_req || too_many) state_d = S_DONE;
          else                      state_d = S_CHANGE_XY;
        end
      end
      S_CHANGE_XY: begin
        if (cell_valid) state_d = S_PLACE;
      end
      S_PLACE: begin
        if (last_mine) state_d = S_DONE;
        else           state_d = S_CHANGE_XY;
      end
      S_DONE: begin
        if (bus.ack) state_d = S_INIT;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    count_d   = count_q;
    error_d   = error_q;
    total_d   = total_q;
    safe_en_d = safe_en_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    case (state_q)
      S_INIT: begin
        if (bus.start) begin
          total_d   = bus.total_mines;
          safe_en_d = bus.safe_en;
          sx_d      = bus.safe_x;
          sy_d      = bus.safe_y;
          count_d   = '0;
          error_d   = 1'b0;
          if (!zero_req && too_many) begin
            error_d = 1'b1;
          end else if (!zero_req) begin
            x_d = cand_x;
            y_d = cand_y;
          end
        end
      end
      S_CHANGE_XY: begin
        if (!cell_valid) begin
          x_d = cand_x;
          y_d = cand_y;
        end
      end
      S_PLACE: begin
        // Address stays on the written cell through PLACE; reload only after the write edge.
        count_d = count_inc;
        if (!last_mine) begin
          x_d = cand_x;
          y_d = cand_y;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_tb or negedge reset_tb) begin
    if (!reset_tb) begin
      x_q       <= '0;
      y_q       <= '0;
      count_q   <= '0;
      error_q   <= 1'b0;
      total_q   <= '0;
      safe_en_q <= 1'b0;
      sx_q      <= '0;
      sy_q      <= '0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      count_q   <= count_d;
      error_q   <= error_d;
      total_q   <= total_d;
      safe_en_q <= safe_en_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
    end
  end

  always_comb begin
    bus.q_init      = (state_q == S_INIT);
    bus.q_change_xy = (state_q == S_CHANGE_XY);
    bus.q_place     = (state_q == S_PLACE);
    bus.q_done      = (state_q == S_DONE);
    bus.place_en    = (state_q == S_PLACE);
  end

  assign bus.x            = x_q;
  assign bus.y            = y_q;
  assign bus.placed_count = count_q;
  assign bus.error        = error_q;

endmodule

// File: tb/tb_mine_placer.sv
// Directed bench for mine_placer: an 8x8 instance and a 5x3 instance, each backed by a
// behavioural mine board that records writes and flags duplicates or stray strobes.
module tb_mine_placer;
  logic clk_tb = 1'b0;
  logic reset_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  int checks = 0;
  int errors = 0;

  mine_placer_if #(.WIDTH(8), .HEIGHT(8)) bus_a ();
  mine_placer_if #(.WIDTH(5), .HEIGHT(3)) bus_b ();

  mine_placer #(.WIDTH(8), .HEIGHT(8), .SEED(16'hACE1)) dut_a (
    .clk_tb  (clk_tb),
    .reset_tb(reset_tb),
    .bus     (bus_a)
  );

  mine_placer #(.WIDTH(5), .HEIGHT(3), .SEED(16'h1D0F)) dut_b (
    .clk_tb  (clk_tb),
    .reset_tb(reset_tb),
    .bus     (bus_b)
  );

  // 8x8 board: cell index is {y,x}
  logic [63:0] mine_a;
  logic [5:0]  idx_a;
  logic        clr_a = 1'b1;
  logic        prev_a;
  int          pulses_a, dup_a, viol_a;
  assign idx_a = {bus_a.y, bus_a.x};
  assign bus_a.mine_read_value = mine_a[idx_a];

  always @(posedge clk_tb) begin
    if (clr_a) begin
      mine_a <= '0; pulses_a <= 0; dup_a <= 0; viol_a <= 0; prev_a <= 1'b0;
    end else begin
      prev_a <= bus_a.place_en;
      if (bus_a.place_en) begin
        pulses_a <= pulses_a + 1;
        if (mine_a[idx_a]) dup_a <= dup_a + 1;
        mine_a[idx_a] <= 1'b1;
        if (!bus_a.q_place || prev_a) viol_a <= viol_a + 1;
      end
    end
  end

  // 5x3 board: cell index is y*5+x
  logic [31:0] mine_b;
  logic [4:0]  idx_b;
  logic        clr_b = 1'b1;
  logic        prev_b;
  int          pulses_b, dup_b, viol_b;
  assign idx_b = 5'(bus_b.y) * 5'd5 + 5'(bus_b.x);
  assign bus_b.mine_read_value = mine_b[idx_b];

  always @(posedge clk_tb) begin
    if (clr_b) begin
      mine_b <= '0; pulses_b <= 0; dup_b <= 0; viol_b <= 0; prev_b <= 1'b0;
    end else begin
      prev_b <= bus_b.place_en;
      if (bus_b.place_en) begin
        pulses_b <= pulses_b + 1;
        if (mine_b[idx_b]) dup_b <= dup_b + 1;
        mine_b[idx_b] <= 1'b1;
        if (!bus_b.q_place || prev_b || bus_b.x >= 3'd5 || bus_b.y >= 2'd3)
          viol_b <= viol_b + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic clear_a();
    clr_a = 1'b1; tick(); clr_a = 1'b0;
  endtask

  task automatic start_a(input logic [6:0] total, input logic sen,
                         input logic [2:0] sx, input logic [2:0] sy);
    bus_a.total_mines = total;
    bus_a.safe_en = sen;
    bus_a.safe_x = sx;
    bus_a.safe_y = sy;
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
  endtask

  task automatic wait_done_a(input int budget, input string name);
    int n = 0;
    while (!bus_a.q_done && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (bus_a.q_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: q_done=%b after %0d cycles, required 1", name, bus_a.q_done, n);
    end
  endtask

  task automatic ack_a(input string name);
    bus_a.ack = 1'b1;
    tick();
    bus_a.ack = 1'b0;
    checks++;
    if ({bus_a.q_init, bus_a.q_change_xy, bus_a.q_place, bus_a.q_done} !== 4'b1000) begin
      errors++;
      $display("FAIL %s_ack: flags=%b required 1000", name,
               {bus_a.q_init, bus_a.q_change_xy, bus_a.q_place, bus_a.q_done});
    end
  endtask

  task automatic test_reset();
    reset_tb = 1'b0;
    clr_a = 1'b1;
    clr_b = 1'b1;
    repeat (3) tick();
    reset_tb = 1'b1;
    clr_a = 1'b0;
    clr_b = 1'b0;
    tick();
    checks++;
    if ({bus_a.q_init, bus_a.q_change_xy, bus_a.q_place, bus_a.q_done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags_a: got %b required 1000",
               {bus_a.q_init, bus_a.q_change_xy, bus_a.q_place, bus_a.q_done});
    end
    checks++;
    if (bus_a.x !== 3'd0 || bus_a.y !== 3'd0) begin
      errors++;
      $display("FAIL reset_xy_a: got (%0d,%0d) required (0,0)", bus_a.x, bus_a.y);
    end
    checks++;
    if (bus_a.place_en !== 1'b0 || bus_a.placed_count !== 7'd0 || bus_a.error !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs_a: place_en=%b count=%0d error=%b required 0/0/0",
               bus_a.place_en, bus_a.placed_count, bus_a.error);
    end
    checks++;
    if ({bus_b.q_init, bus_b.q_change_xy, bus_b.q_place, bus_b.q_done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags_b: got %b required 1000",
               {bus_b.q_init, bus_b.q_change_xy, bus_b.q_place, bus_b.q_done});
    end
    $display("reset: done");
  endtask

  task automatic test_random_10();
    clear_a();
    start_a(7'd10, 1'b0, 3'd0, 3'd0);
    checks++;
    if ({bus_a.q_init, bus_a.q_change_xy, bus_a.q_place, bus_a.q_done} !== 4'b0100) begin
      errors++;
      $display("FAIL rand10_first_state: flags=%b required 0100",
               {bus_a.q_init, bus_a.q_change_xy, bus_a.q_place, bus_a.q_done});
    end
    wait_done_a(5000, "rand10");
    checks++;
    if (bus_a.placed_count !== 7'd10 || bus_a.error !== 1'b0) begin
      errors++;
      $display("FAIL rand10_count: count=%0d error=%b required 10/0", bus_a.placed_count, bus_a.error);
    end
    checks++;
    if (pulses_a != 10 || $countones(mine_a) != 10) begin
      errors++;
      $display("FAIL rand10_board: pulses=%0d mines=%0d required 10/10", pulses_a, $countones(mine_a));
    end
    checks++;
    if (dup_a != 0 || viol_a != 0) begin
      errors++;
      $display("FAIL rand10_strobe: dup=%0d viol=%0d required 0/0", dup_a, viol_a);
    end
    $display("random_10: count=%0d pulses=%0d", bus_a.placed_count, pulses_a);
    ack_a("rand10");
    checks++;
    if (bus_a.placed_count !== 7'd10) begin
      errors++;
      $display("FAIL rand10_hold: count=%0d in INIT required 10", bus_a.placed_count);
    end
  endtask

  task automatic test_safe_corner();
    clear_a();
    start_a(7'd60, 1'b1, 3'd0, 3'd0);
    wait_done_a(60000, "corner");
    checks++;
    if (bus_a.placed_count !== 7'd60 || bus_a.error !== 1'b0) begin
      errors++;
      $display("FAIL corner_count: count=%0d error=%b required 60/0", bus_a.placed_count, bus_a.error);
    end
    checks++;
    if (mine_a !== 64'hFFFF_FFFF_FFFF_FCFC) begin
      errors++;
      $display("FAIL corner_board: board=%h required fffffffffffffcfc", mine_a);
    end
    checks++;
    if (dup_a != 0 || viol_a != 0) begin
      errors++;
      $display("FAIL corner_strobe: dup=%0d viol=%0d required 0/0", dup_a, viol_a);
    end
    $display("safe_corner: count=%0d board=%h", bus_a.placed_count, mine_a);
    ack_a("corner");
  endtask

  task automatic test_capacity_error();
    clear_a();
    start_a(7'd56, 1'b1, 3'd3, 3'd3);
    checks++;
    if ({bus_a.q_init, bus_a.q_change_xy, bus_a.q_place, bus_a.q_done} !== 4'b0001
        || bus_a.error !== 1'b1 || bus_a.placed_count !== 7'd0) begin
      errors++;
      $display("FAIL caperr_done: flags=%b error=%b count=%0d required 0001/1/0",
               {bus_a.q_init, bus_a.q_change_xy, bus_a.q_place, bus_a.q_done},
               bus_a.error, bus_a.placed_count);
    end
    repeat (4) tick();
    checks++;
    if (pulses_a != 0) begin
      errors++;
      $display("FAIL caperr_pulses: pulses=%0d required 0", pulses_a);
    end
    ack_a("caperr");
    checks++;
    if (bus_a.error !== 1'b1) begin
      errors++;
      $display("FAIL caperr_hold: error=%b in INIT required 1", bus_a.error);
    end
    $display("capacity_error: error=%b pulses=%0d", bus_a.error, pulses_a);
  endtask

  task automatic test_zero_ack_start();
    start_a(7'd0, 1'b0, 3'd0, 3'd0);
    checks++;
    if ({bus_a.q_init, bus_a.q_change_xy, bus_a.q_place, bus_a.q_done} !== 4'b0001
        || bus_a.placed_count !== 7'd0 || bus_a.error !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: flags=%b count=%0d error=%b required 0001/0/0",
               {bus_a.q_init, bus_a.q_change_xy, bus_a.q_place, bus_a.q_done},
               bus_a.placed_count, bus_a.error);
    end
    bus_a.total_mines = 7'd5;
    bus_a.ack = 1'b1;
    bus_a.start = 1'b1;
    tick();
    bus_a.ack = 1'b0;
    bus_a.start = 1'b0;
    checks++;
    if ({bus_a.q_init, bus_a.q_change_xy, bus_a.q_place, bus_a.q_done} !== 4'b1000) begin
      errors++;
      $display("FAIL zero_ack_start: flags=%b required 1000",
               {bus_a.q_init, bus_a.q_change_xy, bus_a.q_place, bus_a.q_done});
    end
    repeat (5) tick();
    checks++;
    if (bus_a.q_init !== 1'b1 || pulses_a != 0 || bus_a.place_en !== 1'b0) begin
      errors++;
      $display("FAIL zero_no_restart: q_init=%b pulses=%0d place_en=%b required 1/0/0",
               bus_a.q_init, pulses_a, bus_a.place_en);
    end
    $display("zero_ack_start: q_init=%b pulses=%0d", bus_a.q_init, pulses_a);
  endtask

  task automatic test_small_board();
    int n = 0;
    clr_b = 1'b1; tick(); clr_b = 1'b0;
    bus_b.total_mines = 4'd15;
    bus_b.safe_en = 1'b0;
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    while (!bus_b.q_done && n < 20000) begin
      tick();
      n++;
    end
    checks++;
    if (bus_b.q_done !== 1'b1) begin
      errors++;
      $display("FAIL small_done: q_done=%b after %0d cycles, required 1", bus_b.q_done, n);
    end
    checks++;
    if (bus_b.placed_count !== 4'd15 || bus_b.error !== 1'b0) begin
      errors++;
      $display("FAIL small_count: count=%0d error=%b required 15/0", bus_b.placed_count, bus_b.error);
    end
    checks++;
    if (mine_b !== 32'h0000_7FFF || pulses_b != 15) begin
      errors++;
      $display("FAIL small_board: board=%h pulses=%0d required 00007fff/15", mine_b, pulses_b);
    end
    checks++;
    if (dup_b != 0 || viol_b != 0) begin
      errors++;
      $display("FAIL small_strobe: dup=%0d viol=%0d required 0/0", dup_b, viol_b);
    end
    $display("small_board: count=%0d board=%h", bus_b.placed_count, mine_b);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_a();
    start_a(7'd10, 1'b0, 3'd0, 3'd0);
    while (!(bus_a.q_place && pulses_a == 3) && n < 5000) begin
      tick();
      n++;
    end
    checks++;
    if (!(bus_a.q_place === 1'b1 && pulses_a == 3)) begin
      errors++;
      $display("FAIL midrst_reach: q_place=%b pulses=%0d required 1/3", bus_a.q_place, pulses_a);
    end
    reset_tb = 1'b0;
    #1;
    checks++;
    if (bus_a.place_en !== 1'b0 || bus_a.q_init !== 1'b1 || bus_a.q_place !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: place_en=%b q_init=%b q_place=%b required 0/1/0",
               bus_a.place_en, bus_a.q_init, bus_a.q_place);
    end
    checks++;
    if (bus_a.placed_count !== 7'd0 || bus_a.x !== 3'd0 || bus_a.y !== 3'd0) begin
      errors++;
      $display("FAIL midrst_regs: count=%0d x=%0d y=%0d required 0/0/0",
               bus_a.placed_count, bus_a.x, bus_a.y);
    end
    clr_a = 1'b1;
    tick();
    tick();
    clr_a = 1'b0;
    reset_tb = 1'b1;
    tick();
    start_a(7'd10, 1'b0, 3'd0, 3'd0);
    wait_done_a(5000, "midrst");
    checks++;
    if (bus_a.placed_count !== 7'd10 || pulses_a != 10 || $countones(mine_a) != 10 || dup_a != 0) begin
      errors++;
      $display("FAIL midrst_rerun: count=%0d pulses=%0d mines=%0d dup=%0d required 10/10/10/0",
               bus_a.placed_count, pulses_a, $countones(mine_a), dup_a);
    end
    $display("reset_mid: rerun count=%0d", bus_a.placed_count);
  endtask

  initial begin
    bus_a.start = 1'b0; bus_a.ack = 1'b0; bus_a.total_mines = '0;
    bus_a.safe_en = 1'b0; bus_a.safe_x = '0; bus_a.safe_y = '0;
    bus_b.start = 1'b0; bus_b.ack = 1'b0; bus_b.total_mines = '0;
    bus_b.safe_en = 1'b0; bus_b.safe_x = '0; bus_b.safe_y = '0;
    test_reset();
    test_random_10();
    test_safe_corner();
    test_capacity_error();
    test_zero_ack_start();
    test_small_board();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mine_placer.md
# mine_placer

Parametrised mine-placement controller for the minesweeper board datapath, successor to the fixed 8x8 placer. It places a requested number of mines at pseudo-random, distinct cells of a WIDTH x HEIGHT board. It can optionally keep a 3x3 safe zone around the first-click cell mine-free. It drives the shared address and write-enable of the mine board and the adjacency board (incAdjacent), and reads back the mine board combinationally to reject occupied cells.

## Interface
Parameters:
- WIDTH, 8, board columns; 2..256.
- HEIGHT, 8, board rows; 2..256; XW+YW ≤ 15.
- SEED, 16'hACE1, LFSR reset value; must be nonzero.

Derived widths:
- XW = $clog2(WIDTH)
- YW = $clog2(HEIGHT)
- NW = $clog2(WIDTH*HEIGHT+1)

Ports:
- clk_tb  in  1  clock; all state changes on rising edge.
- reset_tb  in  1  reset, asynchronous, active-low.
- start  in  1  begin placement; sampled only in INIT.
- ack  in  1  acknowledge completion; sampled only in DONE.
- total_mines  in  NW  requested mine count; latched on start.
- safe_en  in  1  enable safe-zone exclusion; latched on start.
- safe_x  in  XW  safe-zone centre column; latched on start.
- safe_y  in  YW  safe-zone centre row; latched on start.
- mine_read_value  in  1  combinational mine-board read at (x,y).
- x  out  XW  candidate/write column; drives board read and write address.
- y  out  YW  candidate/write row.
- place_en  out  1  one-cycle write strobe to the mine board (value 1) and the adjacency board (incAdjacent).
- placed_count  out  NW  mines placed so far.
- error  out  1  request exceeded capacity; valid in DONE.
- q_init, q_change_xy, q_place, q_done  out  1 each  one-hot state flags.

## Operation
- The 16-bit Fibonacci LFSR (taps 16,14,13,11) runs free every cycle from reset.
- Candidate cell: cx = lfsr[XW-1:0], cy = lfsr[XW+YW-1:XW].
- Candidate is valid iff all of:
  - cx < WIDTH and cy < HEIGHT;
  - not (safe_en_l and |cx-sx| ≤ 1 and |cy-sy| ≤ 1), using signed compare, so edge clipping is implicit;
  - mine_read_value == 0.
- Capacity = WIDTH*HEIGHT − S.
  - S = 0 if safe_en_l = 0.
  - Otherwise S = cols*rows. cols = 3 minus 1 for each of sx==0 and sx==WIDTH−1; rows likewise for sy. Arithmetic is NW+1 bits wide.
- States:
  - INIT: all strobes low. On start, latch inputs and clear placed_count and error.
    - total_mines == 0 → DONE.
    - total_mines > capacity → DONE with error = 1.
    - Otherwise load x,y from the LFSR → CHANGE_XY.
  - CHANGE_XY: evaluate validity on the registered x,y and mine_read_value.
    - Valid → PLACE, x,y held.
    - Invalid → x,y reloaded from the LFSR, stay.
  - PLACE: place_en = 1 (Moore output); placed_count increments at the clock edge ending PLACE.
    - New count == total → DONE.
    - Otherwise reload x,y → CHANGE_XY.
  - DONE: outputs held. On ack → INIT; error and placed_count are held until the next start.
- start outside INIT is ignored. ack outside DONE is ignored.
- Progress guarantee: the LFSR period (65535) visits every (cx,cy) pair because XW+YW ≤ 15. Any free cell is therefore found within 65535 cycles.

## Timing
- Reset values: state INIT (q_init = 1, other flags 0); x = 0, y = 0; place_en = 0; placed_count = 0; error = 0; LFSR = SEED. Reset is asynchronous and immediate, including mid-operation.
- start → state change at the next edge. Error or zero-mine requests reach DONE one cycle after start.
- Each mine costs at least 2 cycles: CHANGE_XY plus PLACE.
- place_en is never high for two consecutive cycles, and never high outside PLACE.
- The board write lands at the edge ending PLACE. mine_read_value reflects it in the following CHANGE_XY cycle, so a cell is never placed twice.
- ack and start both high in DONE: ack is taken, start ignored. A new start is required in INIT.

## Test plan
- 8x8, safe_en=0, total=10 → exactly 10 place_en pulses at distinct (x,y); q_done; placed_count=10; error=0; board shows 10 mines with correct adjacency counts.
- 8x8, safe_en=1, safe=(0,0), total=60 → capacity 60; all cells except (0,0),(1,0),(0,1),(1,1) mined.
- 8x8, safe_en=1, safe=(3,3), total=56 → capacity 55; q_done one cycle after start; error=1; zero place_en pulses.
- WIDTH=5, HEIGHT=3, total=15 → every cell mined; x never ≥5 and y never ≥3 on any place_en; placed_count=15.
- total=0 → DONE next cycle with placed_count=0. ack and start high together in DONE → INIT; placement does not restart until start is pulsed again.
- reset_tb low during PLACE of mine 4 → place_en=0, q_init=1, placed_count=0, x=y=0 immediately. A new start after release completes the full requested count.
